axi_burst_rd_engine: RTL
========================

// Module: axi_burst_rd_engine
// PURPOSE
//  Burst-execution slave for the memcpy burst interface. Accepts one burst request (start/addr/len),
//  issues one AXI4 INCR read (AR channel), collects R beats into a 2-entry output buffer, streams them
//  downstream with valid/ready, and returns busy/done to the memcpy controller. One burst in flight at a time.
// PARAMETERS
//  DATA_W  512  AXI R data width and dout width (one beat = 64 B, ARSIZE fixed 3'b110)
//  ID_W    1    AXI ID width
//  AXI_ID  0    constant ARID driven on every request
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous reset, active high
//  burst_start  in   1       1-cycle request pulse; sampled only in IDLE
//  burst_addr   in   64      byte address; bits [5:0] ignored (forced 0)
//  burst_len    in   8       beats (64 B each), legal 1..64
//  burst_busy   out  1       high whenever state != IDLE
//  burst_done   out  1       1-cycle pulse, burst finished (data delivered or error)
//  m_axi_arvalid/arready  out/in 1    AR handshake
//  m_axi_araddr out  64      {addr[63:6],6'd0}
//  m_axi_arlen  out  8       len-1
//  m_axi_arsize out  3       3'b110;  m_axi_arburst out 2  2'b01 (INCR);  m_axi_arid out ID_W  AXI_ID
//  m_axi_rvalid/rready    in/out 1    R handshake
//  m_axi_rdata  in   DATA_W  read data;  m_axi_rresp in 2;  m_axi_rlast in 1;  m_axi_rid in ID_W
//  dout_valid/dout_ready  out/in 1    downstream handshake
//  dout_data    out  DATA_W  beat data;  dout_last out 1  high on final beat of burst
//  rd_error     out  1       sticky error flag;  err_clr in 1  synchronous clear of rd_error
// BEHAVIOUR
//  Reset: state IDLE; burst_busy, burst_done, arvalid, rready, dout_valid, dout_last, rd_error = 0;
//   araddr/arlen/dout_data = 0; buffer empty, beat counters 0. Reset mid-burst abandons the AXI transaction.
//  States (one-hot): IDLE, CHK, ADDR, DATA, DONE.
//  IDLE: burst_start=1 -> latch aligned addr and len, go CHK. burst_start in any other state ignored.
//  CHK (1 cycle): len==0 -> DONE, no AXI traffic, no error. {1'b0,addr[11:6]}+len > 64 (4KB cross)
//   -> set rd_error, DONE, no AXI traffic. Else -> ADDR.
//  ADDR: arvalid=1 with araddr/arlen stable until arready; on handshake -> DATA. Start-to-arvalid = 2 cycles.
//  DATA: rready = buffer count<2 (combinational from registered count; no other dependency on rvalid).
//   Each R handshake writes beat to buffer, rx_cnt++. Error set on rresp!=2'b00, rid!=AXI_ID, or
//   rlast != (rx_cnt==len-1). Beats after len are not expected; rready drops once rx_cnt==len.
//   Buffer: 2-entry FIFO, dout_valid = !empty, dout_data registered at FIFO head; simultaneous
//   push+pop keeps count. dout_last = head beat index == len-1. tx_cnt counts dout handshakes.
//   Last dout handshake (tx_cnt==len-1) -> DONE. Full back-pressure: dout_ready=0 forever stalls,
//   never drops or overwrites.
//  DONE (1 cycle): burst_done=1, -> IDLE. burst_busy falls same cycle as state returns to IDLE; a new
//   burst_start in the first IDLE cycle is accepted.
//  rd_error: set by any cause above, held until err_clr; set and err_clr in same cycle -> stays set.
//  Counters 7 bits (0..64); arlen = len-1 computed in 8 bits (len 64 -> 63).
// TESTING
//  1. addr=0x1000, len=1, arready=1, single R beat rlast=1, dout_ready=1 -> arlen=0, one dout beat
//     dout_last=1, burst_done pulses once; busy high start+1 .. done cycle.
//  2. addr=0x2040 (bits[5:0]=0x3F too), len=63 -> araddr=0x2040, arlen=62; 63 beats in order, no error.
//  3. len=64, dout_ready toggling 1/0 random, rvalid every cycle -> rready never high with buffer full,
//     all 64 beats delivered unchanged, done after beat 64.
//  4. addr=0x0FC0, len=2 (crosses 4KB) -> no arvalid, rd_error=1, burst_done pulse 2 cycles after start;
//     err_clr -> rd_error=0.
//  5. len=4, rresp=2'b10 on beat 2, rlast early on beat 3 -> rd_error=1, remaining beats still drained,
//     done after 4th dout handshake; len=0 -> done, no AR, no error.
//  6. Assert rst during DATA beat 10 of 32 -> all outputs at reset values next edge; new burst completes.

Source files
------------

// File: rtl/axi_burst_rd_engine.sv
// axi_burst_rd_engine
//   Executes one memcpy burst as a single AXI4 INCR read. The AR request is
//   issued only after a 4KB-boundary check. R beats land in a 2-entry buffer
//   that drains to a valid/ready stream.
// Ports
//   clk, rst                       clock, async active-high reset
//   burst_start/addr/len           request (sampled only in IDLE)
//   burst_busy, burst_done         status back to the memcpy controller
//   m_axi_ar*                      AXI read address channel (master side)
//   m_axi_r*                       AXI read data channel (master side)
//   dout_valid/ready/data/last     downstream beat stream
//   rd_error, err_clr              sticky error flag and its synchronous clear
module axi_burst_rd_engine #(
    parameter int              DATA_W = 512,
    parameter int              ID_W   = 1,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              burst_start,
    input  logic [63:0]       burst_addr,
    input  logic [7:0]        burst_len,
    output logic              burst_busy,
    output logic              burst_done,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [63:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [ID_W-1:0]   m_axi_arid,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic [ID_W-1:0]   m_axi_rid,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    output logic              rd_error,
    input  logic              err_clr
);

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_CHK  = 5'b00010;
    localparam logic [4:0] S_ADDR = 5'b00100;
    localparam logic [4:0] S_DATA = 5'b01000;
    localparam logic [4:0] S_DONE = 5'b10000;

    logic [4:0]        state;
    logic [7:0]        len_q;
    logic [6:0]        rx_cnt, tx_cnt;
    logic [1:0]        buf_cnt;
    logic [DATA_W-1:0] head_data, tail_data;
    logic              head_last, tail_last;

    logic       r_hs, d_hs, rx_is_last, tx_is_last, cross_4k, r_err, chk_err;
    logic [8:0] end_beat;

    assign m_axi_arsize  = 3'b110;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = AXI_ID;
    assign m_axi_arvalid = (state == S_ADDR);
    assign burst_busy    = (state != S_IDLE);
    assign burst_done    = (state == S_DONE);

    // rready depends only on registered state, never on rvalid.
    assign m_axi_rready = (state == S_DATA) && (buf_cnt < 2'd2) && ({1'b0, rx_cnt} != len_q);
    assign dout_valid   = (buf_cnt != 2'd0);
    assign dout_data    = head_data;
    assign dout_last    = dout_valid && head_last;

    assign r_hs       = m_axi_rvalid && m_axi_rready;
    assign d_hs       = dout_valid && dout_ready;
    assign rx_is_last = ({1'b0, rx_cnt} == len_q - 8'd1);
    assign tx_is_last = ({1'b0, tx_cnt} == len_q - 8'd1);

    // Beat position of the burst end inside its 4KB page; beyond 64 beats crosses.
    assign end_beat = {3'b000, m_axi_araddr[11:6]} + {1'b0, len_q};
    assign cross_4k = (end_beat > 9'd64);
    assign chk_err  = (state == S_CHK) && (len_q != 8'd0) && cross_4k;
    assign r_err    = r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rid != AXI_ID) ||
                               (m_axi_rlast != rx_is_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            len_q        <= 8'd0;
            m_axi_araddr <= 64'd0;
            m_axi_arlen  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: if (burst_start) begin
                    m_axi_araddr <= {burst_addr[63:6], 6'd0};
                    m_axi_arlen  <= burst_len - 8'd1;
                    len_q        <= burst_len;
                    state        <= S_CHK;
                end
                S_CHK:  state <= ((len_q == 8'd0) || cross_4k) ? S_DONE : S_ADDR;
                S_ADDR: if (m_axi_arready) state <= S_DATA;
                S_DATA: if (d_hs && tx_is_last) state <= S_DONE;
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt <= 7'd0;
            tx_cnt <= 7'd0;
        end else if (state == S_IDLE) begin
            rx_cnt <= 7'd0;
            tx_cnt <= 7'd0;
        end else begin
            if (r_hs) rx_cnt <= rx_cnt + 7'd1;
            if (d_hs) tx_cnt <= tx_cnt + 7'd1;
        end
    end

    // Two-entry buffer: head feeds dout directly, tail holds the second beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cnt   <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({r_hs, d_hs})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        head_data <= m_axi_rdata;
                        head_last <= rx_is_last;
                    end else begin
                        tail_data <= m_axi_rdata;
                        tail_last <= rx_is_last;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    buf_cnt   <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Push only happens below full, so count is 1: new beat goes straight to head.
                    head_data <= m_axi_rdata;
                    head_last <= rx_is_last;
                end
                default: ;
            endcase
        end
    end

    // Set wins over clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  rd_error <= 1'b0;
        else if (r_err || chk_err) rd_error <= 1'b1;
        else if (err_clr)         rd_error <= 1'b0;
    end

endmodule
